// File: rtl/moore_t_fsm.sv
// moore_t_fsm: overlapping serial pattern detector (Moore machine).
// State k means the last k received bits equal the first k pattern bits.
// The state register is built from T flip-flops (toggle when T=1). The
// transition table is derived from PATTERN at elaboration time with a
// KMP-style longest prefix/suffix search.
module moore_t_fsm #(
  parameter int                  PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0]  PATTERN = 4'b1011
) (
  input  logic clk,
  input  logic reset,
  input  logic x,
  output logic z
);

  localparam int             SW     = $clog2(PAT_LEN + 1);
  localparam int             NENC   = 2 ** SW;
  localparam logic [SW-1:0]  S_FULL = SW'(PAT_LEN);

  // Next state from state k on input bit xb. The candidate string is the
  // first k pattern bits followed by xb. Pattern bit j (j = 0 first on the
  // wire) is PATTERN[PAT_LEN-1-j]. Returns the longest pattern prefix that is
  // also a suffix of the string, capped at PAT_LEN. Lengths are tried in
  // ascending order so the last hit is the longest.
  function automatic int next_k(input int k, input logic xb);
    int   best;
    int   idx;
    logic ok;
    logic sb;
    logic pb;
    best = 0;
    for (int l = 1; l <= PAT_LEN; l++) begin
      if (l <= k + 1) begin
        ok = 1'b1;
        for (int j = 0; j < PAT_LEN; j++) begin
          if (j < l) begin
            idx = k + 1 - l + j;
            if (idx == k) begin
              sb = xb;
            end else begin
              sb = PATTERN[PAT_LEN-1-idx];
            end
            pb = PATTERN[PAT_LEN-1-j];
            if (sb != pb) begin
              ok = 1'b0;
            end
          end
        end
        if (ok) begin
          best = l;
        end
      end
    end
    return best;
  endfunction

  // Transition table indexed by the full state encoding; encodings above
  // PAT_LEN are unused and map back to S0 for either input value.
  logic [SW-1:0] tbl0_s [NENC];
  logic [SW-1:0] tbl1_s [NENC];

  for (genvar g = 0; g < NENC; g++) begin : g_tbl
    if (g <= PAT_LEN) begin : g_used
      localparam logic [SW-1:0] N0 = SW'(next_k(g, 1'b0));
      localparam logic [SW-1:0] N1 = SW'(next_k(g, 1'b1));
      assign tbl0_s[g] = N0;
      assign tbl1_s[g] = N1;
    end else begin : g_unused
      assign tbl0_s[g] = '0;
      assign tbl1_s[g] = '0;
    end
  end

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;
  logic [SW-1:0] nxt_s;
  logic [SW-1:0] t_s;
  logic          z_q;
  logic          z_d;

  // Next-state lookup, T inputs, toggled state bits and output decode.
  always_comb begin
    nxt_s   = '0;
    t_s     = '0;
    state_d = state_q;
    z_d     = 1'b0;
    if (x) begin
      nxt_s = tbl1_s[state_q];
    end else begin
      nxt_s = tbl0_s[state_q];
    end
    t_s = state_q ^ nxt_s;
    for (int i = 0; i < SW; i++) begin
      if (t_s[i]) begin
        state_d[i] = ~state_q[i];
      end else begin
        state_d[i] = state_q[i];
      end
    end
    // z_q tracks (state_q == PAT_LEN) exactly: it is decoded from the value
    // the state register is about to load, so z never sees x directly.
    if (state_d == S_FULL) begin
      z_d = 1'b1;
    end else begin
      z_d = 1'b0;
    end
  end

  // T flip-flop state bits and output flop, asynchronously cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
    end
  end

  assign z = z_q;

endmodule

// File: tb/tb_moore_t_fsm.sv
// tb_moore_t_fsm: directed-vector bench for moore_t_fsm. One instance uses
// the default pattern 1011, a second uses PAT_LEN=3, PATTERN=111.
module tb_moore_t_fsm;

  logic clk;
  logic reset;
  logic x;
  logic x3;
  logic z;
  logic z3;

  int n_checks;
  int n_fail;

  moore_t_fsm dut (
    .clk   (clk),
    .reset (reset),
    .x     (x),
    .z     (z)
  );

  moore_t_fsm #(
    .PAT_LEN (3),
    .PATTERN (3'b111)
  ) dut3 (
    .clk   (clk),
    .reset (reset),
    .x     (x3),
    .z     (z3)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one bit on the falling edge, then check state and z after the rising edge.
  task automatic step(input logic xb, input int exp_state, input logic exp_z, input string tag);
    @(negedge clk);
    x = xb;
    @(posedge clk);
    #1;
    check_eq({tag, "_state"}, 32'(dut.state_q), 32'(exp_state));
    check_eq({tag, "_z"}, 32'(z), 32'(exp_z));
  endtask

  task automatic step3(input int exp_state, input logic exp_z, input string tag);
    @(posedge clk);
    #1;
    check_eq({tag, "_state"}, 32'(dut3.state_q), 32'(exp_state));
    check_eq({tag, "_z"}, 32'(z3), 32'(exp_z));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    x        = 1'b0;
    x3       = 1'b0;

    // Reset before any clock edge.
    #1;
    check_eq("rst_pre_state", 32'(dut.state_q), 32'd0);
    check_eq("rst_pre_z", 32'(z), 32'd0);
    // Still in reset after an edge.
    @(posedge clk);
    #1;
    check_eq("rst_hold_state", 32'(dut.state_q), 32'd0);
    check_eq("rst_hold_z", 32'(z), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // First detection of 1011.
    step(1'b0, 0, 1'b0, "a0");
    step(1'b1, 1, 1'b0, "a1");
    step(1'b0, 2, 1'b0, "a2");
    step(1'b1, 3, 1'b0, "a3");
    step(1'b1, 4, 1'b1, "a4");
    // Overlap: 0,1,1 after S4.
    step(1'b0, 2, 1'b0, "b0");
    step(1'b1, 3, 1'b0, "b1");
    step(1'b1, 4, 1'b1, "b2");
    // 1 after S4 goes to S1, then S1 holds on more 1s.
    step(1'b1, 1, 1'b0, "c0");
    step(1'b1, 1, 1'b0, "c1");
    step(1'b1, 1, 1'b0, "c2");
    step(1'b1, 1, 1'b0, "c3");
    // Back up to S3.
    step(1'b0, 2, 1'b0, "d0");
    step(1'b1, 3, 1'b0, "d1");

    // Asynchronous reset between edges while in S3.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_state", 32'(dut.state_q), 32'd0);
    check_eq("arst_z", 32'(z), 32'd0);
    @(posedge clk);
    #1;
    check_eq("arst_hold_state", 32'(dut.state_q), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    // Pattern straddling reset is not detected.
    step(1'b1, 1, 1'b0, "e0");
    step(1'b1, 1, 1'b0, "e1");
    // Reset during z=1 clears the output.
    step(1'b0, 2, 1'b0, "f0");
    step(1'b1, 3, 1'b0, "f1");
    step(1'b1, 4, 1'b1, "f2");
    #2;
    reset = 1'b1;
    #1;
    check_eq("zrst_z", 32'(z), 32'd0);
    check_eq("zrst_state", 32'(dut.state_q), 32'd0);

    // PAT_LEN=3, PATTERN=111 with x held at 1: z from the third edge on.
    @(negedge clk);
    x3    = 1'b1;
    reset = 1'b0;
    step3(1, 1'b0, "p1");
    step3(2, 1'b0, "p2");
    step3(3, 1'b1, "p3");
    step3(3, 1'b1, "p4");
    step3(3, 1'b1, "p5");
    // A 0 breaks the run.
    @(negedge clk);
    x3 = 1'b0;
    step3(0, 1'b0, "p6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
